// File: rtl/stage_mem.sv
// Pipeline MEM stage: byte-serial load/store engine over an 8-bit RAM port.
// Optional misalignment trap is enabled by defining MEM_ALIGN_CHECK_EN.
module stage_mem #(
    parameter logic [6:0] LOAD_OP  = 7'b0000011,
    parameter logic [6:0] STORE_OP = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  ram_din_i,
    output logic [31:0] ram_a_o,
    output logic [7:0]  ram_dout_o,
    output logic        ram_wr_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  wd_q, wd_d;
    logic        wreg_q, wreg_d;
    logic        load_q, load_d;
    logic        refetch_q, refetch_d;
    logic        mis_q, mis_d;

    logic        is_mem;
    logic        req;
    logic        mis;
    logic [2:0]  last_idx;
    logic [2:0]  cap_idx;
    logic [2:0]  a_idx;
    logic [31:0] ld_ext;

    assign is_mem = ((opcode_i == LOAD_OP) || (opcode_i == STORE_OP)) && (funct3_i[1:0] != 2'b11);
    assign req    = (state_q == S_IDLE) && is_mem;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = ((funct3_i[1:0] == 2'b01) && mem_addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        case (f3_q[1:0])
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            default: last_idx = 3'd3;
        endcase
    end

    assign cap_idx = cnt_q - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            sdata_q   <= '0;
            ldata_q   <= '0;
            f3_q      <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            load_q    <= 1'b0;
            refetch_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            sdata_q   <= sdata_d;
            ldata_q   <= ldata_d;
            f3_q      <= f3_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            load_q    <= load_d;
            refetch_q <= refetch_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        sdata_d   = sdata_q;
        ldata_d   = ldata_q;
        f3_d      = f3_q;
        wd_d      = wd_q;
        wreg_d    = wreg_q;
        load_d    = load_q;
        refetch_d = refetch_q;
        mis_d     = mis_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_d   = mis ? S_DONE : S_BUSY;
                        cnt_d     = '0;
                        base_d    = mem_addr_i;
                        sdata_d   = wdata_i;
                        ldata_d   = '0;
                        f3_d      = funct3_i;
                        wd_d      = wd_i;
                        wreg_d    = wreg_i;
                        load_d    = (opcode_i == LOAD_OP);
                        refetch_d = 1'b0;
                        mis_d     = mis;
                    end
                end
                S_BUSY: begin
                    // A refetch cycle only re-issues the lost address; capture resumes next cycle.
                    if (refetch_q) begin
                        refetch_d = 1'b0;
                    end else begin
                        if (load_q && (cnt_q != 3'd0)) begin
                            for (int unsigned i = 0; i < 4; i++)
                                if (cap_idx == 3'(i)) ldata_d[8*i +: 8] = ram_din_i;
                        end
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == last_idx) state_d = load_q ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (refetch_q) begin
                        refetch_d = 1'b0;
                    end else begin
                        for (int unsigned i = 0; i < 4; i++)
                            if (cap_idx == 3'(i)) ldata_d[8*i +: 8] = ram_din_i;
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (load_q && (((state_q == S_BUSY) && (cnt_q != 3'd0)) || (state_q == S_WAIT))) begin
            // The byte arriving during a pause is dropped; remember to re-read it on resume.
            refetch_d = 1'b1;
        end
    end

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ldata_q[7]}}, ldata_q[7:0]};
            3'b001:  ld_ext = {{16{ldata_q[15]}}, ldata_q[15:0]};
            3'b100:  ld_ext = {24'd0, ldata_q[7:0]};
            3'b101:  ld_ext = {16'd0, ldata_q[15:0]};
            default: ld_ext = ldata_q;
        endcase
    end

    always_comb begin
        ram_a_o    = '0;
        ram_dout_o = '0;
        ram_wr_o   = 1'b0;
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stall_o    = 1'b0;
        a_idx      = cnt_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_o = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                stall_o = req;
                if (!is_mem) begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
            end
            S_BUSY: begin
                stall_o  = 1'b1;
                a_idx    = (refetch_q && rdy) ? cap_idx : cnt_q;
                ram_a_o  = base_q + {29'd0, a_idx};
                ram_wr_o = !load_q && rdy;
                for (int unsigned i = 0; i < 4; i++)
                    if (cnt_q == 3'(i)) ram_dout_o = sdata_q[8*i +: 8];
            end
            S_WAIT: begin
                stall_o = 1'b1;
                ram_a_o = base_q + {29'd0, cap_idx};
            end
            default: begin
                wd_o    = wd_q;
                wreg_o  = load_q && wreg_q;
                wdata_o = (load_q && !mis_q) ? ld_ext : '0;
`ifdef MEM_ALIGN_CHECK_EN
                misalign_o = mis_q;
`endif
            end
        endcase
        if (rst) begin
            ram_a_o    = '0;
            ram_dout_o = '0;
            ram_wr_o   = 1'b0;
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            stall_o    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o = 1'b0;
`endif
        end
    end

endmodule
